mtl_display_ctrl: RTL and testbench
===================================

Name: mtl_display_ctrl

Overview:
- Parametrised second-generation MTL LCD controller. Generates H/V timing from generic porch parameters and fetches pixels from the SDRAM read FIFO.
- Selects the displayed source per frame: game layer, loading colour, or SDRAM. Source changes only take effect at frame boundaries, which allows tear-free reload.
- Sits between the SDRAM read port, the game renderer and the MTL panel pins. It replaces the fixed-timing controller.

Parameters:
- H_ACTIVE, 800, visible pixels per line
- H_BLANK, 46, HSYNC plus back porch (cycles)
- H_FRONT, 210, horizontal front porch
- V_ACTIVE, 480, visible lines
- V_BLANK, 23, VSYNC plus back porch (lines)
- V_FRONT, 22, vertical front porch
- H_SYNC, 1, HSYNC low width (cycles, ≤H_BLANK)
- V_SYNC, 1, VSYNC low width (lines, ≤V_BLANK)
- COLOR_W, 8, bits per colour channel
- RD_LATENCY, 1, cycles from read enable/coordinate to valid data (1..H_BLANK-1)
- LOAD_COLOR, 24'hFFFFFF, loading-screen RGB (top COLOR_W bits of each byte used)

Ports:
- iCLK  in  1  pixel clock (33 MHz)
- iRST_n  in  1  asynchronous active-low reset
- iLoading  in  1  high while the slideshow is loading into SDRAM
- iTestPattern  in  1  colour-bar request (used only with the macro)
- iREAD_DATA  in  32  SDRAM pixel; R=[23:16], G=[15:8], B=[7:0]
- iGAME_R/G/B  in  COLOR_W each  game-layer colour for oX/oY
- oREAD_SDRAM_EN  out  1  SDRAM FIFO read request
- oX  out  11  active-area column being fetched
- oY  out  10  active-area line being fetched
- oNewFrame  out  1  one-cycle pulse at the start of a frame
- oEndFrame  out  1  one-cycle pulse at the last active pixel
- oHD  out  1  HSYNC, active low
- oVD  out  1  VSYNC, active low
- oDE  out  1  data enable aligned with colour
- oLCD_R/G/B  out  COLOR_W each  panel colour

Behaviour:
- H_TOTAL=H_BLANK+H_ACTIVE+H_FRONT; V_TOTAL similarly.
- Counters x (0..H_TOTAL-1) and y (0..V_TOTAL-1). y increments when x wraps.
- Counters reset to (H_TOTAL-1, V_TOTAL-1), so the first clock after reset enters (0,0).
- act(x,y) = H_BLANK≤x<H_BLANK+H_ACTIVE and V_BLANK≤y<V_BLANK+V_ACTIVE.
- Fetch window: oREAD_SDRAM_EN=1 iff act(x+RD_LATENCY, y) and src≠S_GAME (or src=S_RUN when test pattern inactive).
  - oX/oY = coordinates of that lookahead position, held at 0 outside the window.
  - Exactly H_ACTIVE enables per active line.
- Stage 1 (registered when act(x,y)): selects colour from src.
  - S_GAME: iGAME_*
  - S_LOAD: LOAD_COLOR
  - S_RUN: iREAD_DATA
  - Outside the active area the colour is 0.
- Stage 2: registers oLCD_*, oDE, oHD (low when x<H_SYNC), oVD (low when y<V_SYNC).
  - Pixel, sync and DE latency = 2 cycles from the counter, identical for all of them.
- oNewFrame is registered and high during the cycle the counters equal (0,0).
- oEndFrame is registered and high during the cycle the counters equal (H_BLANK+H_ACTIVE-1, V_BLANK+V_ACTIVE-1).
- Source FSM (src register) plus a pending flag:
  - S_GAME → S_LOAD: iLoading=1 sampled at frame start.
  - S_LOAD → S_RUN: at frame start with iLoading=0.
  - S_RUN → S_LOAD: at frame start with iLoading=1 (reload).
  - iLoading pulses between frame starts are latched in pend_load, cleared at the frame start that consumes them.
  - Frame start = counter transition to (0,0).
- Reset mid-frame: all outputs 0 (oHD=oVD=0), src=S_GAME, pend_load=0, counters as above. No partial line is emitted after release.
- Simultaneous iLoading=1 and frame start: the transition happens at that frame start.

Optional Feature:
- MTL_TEST_PATTERN_EN defined:
  - When iTestPattern=1 (sampled at frame start), stage 1 outputs 8 vertical bars of width H_ACTIVE/8 in the order white, yellow, cyan, green, magenta, red, blue, black. The last bar absorbs any remainder.
  - oREAD_SDRAM_EN is forced 0 for that frame.
- Macro undefined: iTestPattern is ignored, no bar logic.

Decomposition:
- mtl_pkg:
  - typedef enum src_t {S_GAME, S_LOAD, S_RUN}
  - rgb_t struct
  - default timing constants
  - bar colour table
- Sub-module mtl_timing_gen: counters, act/lookahead flags, sync decode, frame pulses.
- Top: source FSM, colour pipeline, fetch outputs.

Test Plan:
- Small timing (H_ACTIVE=8, H_BLANK=3, H_FRONT=2, V_ACTIVE=4, V_BLANK=2, V_FRONT=1), release reset → oNewFrame at cycle 1, period 13×7=91 cycles; oHD low 1 cycle per line at 2-cycle lag.
- S_RUN with RD_LATENCY=1: feed iREAD_DATA=count of enables → oLCD_R sequence 0..7 per line, oDE high exactly 8 cycles, 32 enables per frame.
- Pulse iLoading for 1 cycle mid-frame from S_GAME → source stays game until next oNewFrame, then LOAD_COLOR on all active pixels.
- iLoading held low from S_LOAD → S_RUN at the next frame start; later iLoading=1 → back to S_LOAD at the following frame start.
- Assert iRST_n=0 at pixel (5,3) → outputs 0 immediately; after release, src=S_GAME and the first oNewFrame comes 1 cycle later.
- MTL_TEST_PATTERN_EN with iTestPattern=1 → first bar FFFFFF, last bar 000000, zero oREAD_SDRAM_EN in that frame.

Source files
------------

// File: rtl/mtl_pkg.sv
// mtl_pkg: shared types, default panel timing and colour-bar table for the MTL display controller.
package mtl_pkg;

    typedef enum logic [1:0] {S_GAME, S_LOAD, S_RUN} src_t;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    localparam int X_W = 11;
    localparam int Y_W = 10;

    localparam int DEF_H_ACTIVE = 800;
    localparam int DEF_H_BLANK = 46;
    localparam int DEF_H_FRONT = 210;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_BLANK = 23;
    localparam int DEF_V_FRONT = 22;
    localparam int DEF_H_SYNC = 1;
    localparam int DEF_V_SYNC = 1;
    localparam int DEF_COLOR_W = 8;
    localparam int DEF_RD_LATENCY = 1;
    localparam logic [23:0] DEF_LOAD_COLOR = 24'hFFFFFF;

    // Index 0 is the leftmost bar: white, yellow, cyan, green, magenta, red, blue, black.
    localparam logic [7:0][23:0] BAR_COLORS = {
        24'h000000, 24'h0000FF, 24'hFF0000, 24'hFF00FF,
        24'h00FF00, 24'h00FFFF, 24'hFFFF00, 24'hFFFFFF
    };

    function automatic rgb_t bar_rgb(input logic [2:0] idx);
        return rgb_t'(BAR_COLORS[idx]);
    endfunction

endpackage

// File: rtl/mtl_timing_gen.sv
// mtl_timing_gen: H/V counters, active and fetch-lookahead windows, sync decode and frame pulses.
module mtl_timing_gen
    import mtl_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_BLANK = DEF_H_BLANK,
    parameter int H_FRONT = DEF_H_FRONT,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_BLANK = DEF_V_BLANK,
    parameter int V_FRONT = DEF_V_FRONT,
    parameter int H_SYNC = DEF_H_SYNC,
    parameter int V_SYNC = DEF_V_SYNC,
    parameter int RD_LATENCY = DEF_RD_LATENCY
) (
    input  logic           clk,
    input  logic           rst_n,
    output logic           act,
    output logic           look,
    output logic           hs,
    output logic           vs,
    output logic           frame_start,
    output logic [X_W-1:0] col,
    output logic [X_W-1:0] fx,
    output logic [Y_W-1:0] fy,
    output logic           new_frame,
    output logic           end_frame
);

    localparam int H_TOTAL = H_BLANK + H_ACTIVE + H_FRONT;
    localparam int V_TOTAL = V_BLANK + V_ACTIVE + V_FRONT;
    localparam logic [X_W-1:0] X_LAST = X_W'(H_TOTAL - 1);
    localparam logic [X_W-1:0] X_ACT0 = X_W'(H_BLANK);
    localparam logic [X_W-1:0] X_ACT1 = X_W'(H_BLANK + H_ACTIVE);
    localparam logic [X_W-1:0] X_END = X_W'(H_BLANK + H_ACTIVE - 1);
    localparam logic [X_W-1:0] X_SYNC = X_W'(H_SYNC);
    localparam logic [X_W-1:0] X_LAT = X_W'(RD_LATENCY);
    localparam logic [Y_W-1:0] Y_LAST = Y_W'(V_TOTAL - 1);
    localparam logic [Y_W-1:0] Y_ACT0 = Y_W'(V_BLANK);
    localparam logic [Y_W-1:0] Y_ACT1 = Y_W'(V_BLANK + V_ACTIVE);
    localparam logic [Y_W-1:0] Y_END = Y_W'(V_BLANK + V_ACTIVE - 1);
    localparam logic [Y_W-1:0] Y_SYNC = Y_W'(V_SYNC);

    logic [X_W-1:0] x, x_nxt, xl;
    logic [Y_W-1:0] y, y_nxt;
    logic x_wrap, v_act;

    assign x_wrap = x == X_LAST;
    assign x_nxt = x_wrap ? '0 : x + 1'b1;
    assign y_nxt = !x_wrap ? y : (y == Y_LAST ? '0 : y + 1'b1);
    assign frame_start = x_wrap && y == Y_LAST;

    // The lookahead never wraps into the next line because RD_LATENCY stays below H_BLANK.
    assign xl = x + X_LAT;
    assign v_act = y >= Y_ACT0 && y < Y_ACT1;
    assign act = v_act && x >= X_ACT0 && x < X_ACT1;
    assign look = v_act && xl >= X_ACT0 && xl < X_ACT1;
    assign hs = x >= X_SYNC;
    assign vs = y >= Y_SYNC;
    assign col = x - X_ACT0;
    assign fx = look ? xl - X_ACT0 : '0;
    assign fy = look ? y - Y_ACT0 : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x <= X_LAST;
            y <= Y_LAST;
            new_frame <= 1'b0;
            end_frame <= 1'b0;
        end else begin
            x <= x_nxt;
            y <= y_nxt;
            new_frame <= frame_start;
            end_frame <= x_nxt == X_END && y_nxt == Y_END;
        end
    end

endmodule

// File: rtl/mtl_display_ctrl.sv
// mtl_display_ctrl: MTL LCD controller with per-frame source selection (game, loading colour, SDRAM).
// Define MTL_TEST_PATTERN_EN to add the colour-bar test pattern selected by iTestPattern.
module mtl_display_ctrl
    import mtl_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_BLANK = DEF_H_BLANK,
    parameter int H_FRONT = DEF_H_FRONT,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_BLANK = DEF_V_BLANK,
    parameter int V_FRONT = DEF_V_FRONT,
    parameter int H_SYNC = DEF_H_SYNC,
    parameter int V_SYNC = DEF_V_SYNC,
    parameter int COLOR_W = DEF_COLOR_W,
    parameter int RD_LATENCY = DEF_RD_LATENCY,
    parameter logic [23:0] LOAD_COLOR = DEF_LOAD_COLOR
) (
    input  logic               iCLK,
    input  logic               iRST_n,
    input  logic               iLoading,
    input  logic               iTestPattern,
    input  logic [31:0]        iREAD_DATA,
    input  logic [COLOR_W-1:0] iGAME_R,
    input  logic [COLOR_W-1:0] iGAME_G,
    input  logic [COLOR_W-1:0] iGAME_B,
    output logic               oREAD_SDRAM_EN,
    output logic [X_W-1:0]     oX,
    output logic [Y_W-1:0]     oY,
    output logic               oNewFrame,
    output logic               oEndFrame,
    output logic               oHD,
    output logic               oVD,
    output logic               oDE,
    output logic [COLOR_W-1:0] oLCD_R,
    output logic [COLOR_W-1:0] oLCD_G,
    output logic [COLOR_W-1:0] oLCD_B
);

    localparam rgb_t LC = LOAD_COLOR;

    logic act, look, hs, vs, frame_start, pend, pend_nxt, tp, unused;
    logic [X_W-1:0] col;
    src_t src, src_nxt;
    rgb_t rd;
    logic [COLOR_W-1:0] c_r, c_g, c_b, s1_r, s1_g, s1_b;
    logic s1_de, s1_hs, s1_vs;

    mtl_timing_gen #(
        .H_ACTIVE(H_ACTIVE), .H_BLANK(H_BLANK), .H_FRONT(H_FRONT),
        .V_ACTIVE(V_ACTIVE), .V_BLANK(V_BLANK), .V_FRONT(V_FRONT),
        .H_SYNC(H_SYNC), .V_SYNC(V_SYNC), .RD_LATENCY(RD_LATENCY)
    ) u_timing (
        .clk(iCLK),
        .rst_n(iRST_n),
        .act(act),
        .look(look),
        .hs(hs),
        .vs(vs),
        .frame_start(frame_start),
        .col(col),
        .fx(oX),
        .fy(oY),
        .new_frame(oNewFrame),
        .end_frame(oEndFrame)
    );

    // Loading requests seen mid-frame are held until the next frame boundary.
    always_comb begin
        src_nxt = src;
        pend_nxt = pend | iLoading;
        if (frame_start) begin
            pend_nxt = 1'b0;
            src_nxt = src == S_LOAD ? (iLoading ? S_LOAD : S_RUN) : (iLoading || pend) ? S_LOAD : src;
        end
    end

    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) begin
            src <= S_GAME;
            pend <= 1'b0;
        end else begin
            src <= src_nxt;
            pend <= pend_nxt;
        end
    end

`ifdef MTL_TEST_PATTERN_EN
    localparam int BW = H_ACTIVE / 8;
    logic [X_W-1:0] bi;
    rgb_t bar;

    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) tp <= 1'b0;
        else if (frame_start) tp <= iTestPattern;
    end

    assign bi = col / X_W'(BW);
    assign bar = bar_rgb(bi > X_W'(7) ? 3'd7 : bi[2:0]);
    assign unused = ^iREAD_DATA[31:24];
`else
    assign tp = 1'b0;
    assign unused = ^{iREAD_DATA[31:24], iTestPattern, col};
`endif

    assign rd = iREAD_DATA[23:0];
    assign oREAD_SDRAM_EN = look && src != S_GAME && !tp;

    always_comb begin
        c_r = src == S_GAME ? iGAME_R : src == S_LOAD ? LC.r[7 -: COLOR_W] : rd.r[7 -: COLOR_W];
        c_g = src == S_GAME ? iGAME_G : src == S_LOAD ? LC.g[7 -: COLOR_W] : rd.g[7 -: COLOR_W];
        c_b = src == S_GAME ? iGAME_B : src == S_LOAD ? LC.b[7 -: COLOR_W] : rd.b[7 -: COLOR_W];
`ifdef MTL_TEST_PATTERN_EN
        if (tp) begin
            c_r = bar.r[7 -: COLOR_W];
            c_g = bar.g[7 -: COLOR_W];
            c_b = bar.b[7 -: COLOR_W];
        end
`endif
    end

    // Two register stages keep colour, DE and both syncs on the same latency.
    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) begin
            {s1_r, s1_g, s1_b, s1_de, s1_hs, s1_vs} <= '0;
            {oLCD_R, oLCD_G, oLCD_B, oDE, oHD, oVD} <= '0;
        end else begin
            s1_r <= act ? c_r : '0;
            s1_g <= act ? c_g : '0;
            s1_b <= act ? c_b : '0;
            s1_de <= act;
            s1_hs <= hs;
            s1_vs <= vs;
            oLCD_R <= s1_r;
            oLCD_G <= s1_g;
            oLCD_B <= s1_b;
            oDE <= s1_de;
            oHD <= s1_hs;
            oVD <= s1_vs;
        end
    end

endmodule

// File: tb/tb_mtl_display_ctrl.sv
// tb_mtl_display_ctrl: scoreboard bench for mtl_display_ctrl on a 13x7 small-timing panel.
module tb_mtl_display_ctrl;

    localparam int K_GAME = 0;
    localparam int K_LOAD = 1;
    localparam int K_RUN = 2;
    localparam int K_BAR = 3;
    localparam logic [23:0] LC = 24'hA5C33C;
    localparam logic [23:0] GAME = 24'h112233;

    logic iCLK = 1'b0;
    logic iRST_n = 1'b0;
    logic iLoading = 1'b0;
    logic iTestPattern = 1'b0;
    logic [31:0] iREAD_DATA = 32'hDEADBEEF;
    logic [7:0] iGAME_R = GAME[23:16];
    logic [7:0] iGAME_G = GAME[15:8];
    logic [7:0] iGAME_B = GAME[7:0];
    logic oREAD_SDRAM_EN, oNewFrame, oEndFrame, oHD, oVD, oDE;
    logic [10:0] oX;
    logic [9:0] oY;
    logic [7:0] oLCD_R, oLCD_G, oLCD_B;

    int tests = 0;
    int fails = 0;
    logic [23:0] pix_q[$];
    int en_q[$];

    mtl_display_ctrl #(
        .H_ACTIVE(8), .H_BLANK(3), .H_FRONT(2),
        .V_ACTIVE(4), .V_BLANK(2), .V_FRONT(1),
        .H_SYNC(1), .V_SYNC(1), .COLOR_W(8), .RD_LATENCY(1), .LOAD_COLOR(LC)
    ) dut (
        .iCLK(iCLK), .iRST_n(iRST_n), .iLoading(iLoading), .iTestPattern(iTestPattern),
        .iREAD_DATA(iREAD_DATA), .iGAME_R(iGAME_R), .iGAME_G(iGAME_G), .iGAME_B(iGAME_B),
        .oREAD_SDRAM_EN(oREAD_SDRAM_EN), .oX(oX), .oY(oY), .oNewFrame(oNewFrame),
        .oEndFrame(oEndFrame), .oHD(oHD), .oVD(oVD), .oDE(oDE),
        .oLCD_R(oLCD_R), .oLCD_G(oLCD_G), .oLCD_B(oLCD_B)
    );

    always #5 iCLK = ~iCLK;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic logic [23:0] bar_exp(input int p);
        case (p)
            0: return 24'hFFFFFF;
            1: return 24'hFFFF00;
            2: return 24'h00FFFF;
            3: return 24'h00FF00;
            4: return 24'hFF00FF;
            5: return 24'hFF0000;
            6: return 24'h0000FF;
            default: return 24'h000000;
        endcase
    endfunction

    task automatic push_frame(input int kind, input int en);
        for (int l = 0; l < 4; l++)
            for (int p = 0; p < 8; p++)
                pix_q.push_back(kind == K_GAME ? GAME : kind == K_LOAD ? LC :
                                kind == K_RUN ? {8'(p), 8'(l), 8'h5A} : bar_exp(p));
        en_q.push_back(en);
    endtask

    task automatic wait_nf(input string name);
        int n = 0;
        do begin
            @(negedge iCLK);
            n++;
        end while (!oNewFrame && n < 200);
        if (!oNewFrame) begin
            tests++;
            fails++;
            $display("FAIL %s: no oNewFrame within %0d cycles", name, n);
        end
    endtask

    // SDRAM model: one cycle after an enable, returns {oX, oY, 5A} captured with that enable.
    initial begin : sdram
        logic en;
        logic [10:0] cx;
        logic [9:0] cy;
        forever begin
            @(negedge iCLK);
            en = oREAD_SDRAM_EN;
            cx = oX;
            cy = oY;
            @(posedge iCLK);
            #1;
            iREAD_DATA = en ? {8'h00, cx[7:0], cy[7:0], 8'h5A} : 32'hDEADBEEF;
        end
    end

    initial begin : monitor
        int en_cnt;
        bit started;
        en_cnt = 0;
        started = 0;
        forever begin
            @(negedge iCLK);
            if (!iRST_n) begin
                en_cnt = 0;
                started = 0;
            end else begin
                if (oNewFrame) begin
                    if (started && en_q.size() > 0) check("frame_enables", en_cnt, en_q.pop_front());
                    started = 1;
                    en_cnt = 0;
                end
                if (oREAD_SDRAM_EN) en_cnt++;
                if (oDE) begin
                    if (pix_q.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL unexpected_de: got rgb %0h with empty queue", {oLCD_R, oLCD_G, oLCD_B});
                    end else check("pixel", {oLCD_R, oLCD_G, oLCD_B}, pix_q.pop_front());
                end
            end
        end
    end

    initial begin : stim
        int hd_low, vd_low, ef_cyc, nf_early;
        repeat (3) @(negedge iCLK);
        check("rst_hd", oHD, 0);
        check("rst_vd", oVD, 0);
        check("rst_de", oDE, 0);
        check("rst_rgb", {oLCD_R, oLCD_G, oLCD_B}, 0);
        check("rst_nf", oNewFrame, 0);
        check("rst_en", oREAD_SDRAM_EN, 0);
        iRST_n = 1'b1;
        @(negedge iCLK);
        check("nf_cycle1", oNewFrame, 1);
        push_frame(K_GAME, 0);
        hd_low = 0;
        vd_low = 0;
        ef_cyc = 0;
        nf_early = 0;
        for (int i = 0; i < 90; i++) begin
            @(negedge iCLK);
            if (i == 0) check("hd_lag_c2", oHD, 1);
            if (i == 1) check("hd_lag_c3", oHD, 0);
            if (i == 1) check("vd_lag_c3", oVD, 0);
            if (i == 2) check("hd_lag_c4", oHD, 1);
            hd_low += int'(!oHD);
            vd_low += int'(!oVD);
            if (oEndFrame) ef_cyc = i + 2;
            if (oNewFrame) nf_early++;
            if (i == 40) iLoading = 1'b1;
            if (i == 41) iLoading = 1'b0;
        end
        @(negedge iCLK);
        check("nf_period", oNewFrame, 1);
        check("nf_early", nf_early, 0);
        check("hd_low_per_frame", hd_low, 7);
        check("vd_low_per_frame", vd_low, 13);
        check("end_frame_cycle", ef_cyc, 76);
        push_frame(K_LOAD, 32);
        wait_nf("to_run");
        push_frame(K_RUN, 32);
        iLoading = 1'b1;
        wait_nf("reload");
        push_frame(K_LOAD, 32);
        iLoading = 1'b0;
        iTestPattern = 1'b1;
        wait_nf("test_pattern_frame");
        iTestPattern = 1'b0;
`ifdef MTL_TEST_PATTERN_EN
        push_frame(K_BAR, 0);
`else
        push_frame(K_RUN, 32);
`endif
        wait_nf("run_again");
        push_frame(K_RUN, 32);
        repeat (44) @(negedge iCLK);
        iRST_n = 1'b0;
        #1;
        check("midrst_hd", oHD, 0);
        check("midrst_vd", oVD, 0);
        check("midrst_de", oDE, 0);
        check("midrst_rgb", {oLCD_R, oLCD_G, oLCD_B}, 0);
        check("midrst_en", oREAD_SDRAM_EN, 0);
        check("midrst_end", oEndFrame, 0);
        pix_q.delete();
        en_q.delete();
        repeat (3) @(negedge iCLK);
        iRST_n = 1'b1;
        @(negedge iCLK);
        check("nf_after_rst", oNewFrame, 1);
        push_frame(K_GAME, 0);
        wait_nf("after_rst_frame");
        @(negedge iCLK);
        check("pix_q_empty", pix_q.size(), 0);
        check("en_q_empty", en_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
